// File: rtl/serializer_piso_stream_pkg.sv
// serializer_piso_stream_pkg
//   Shared transceiver definitions used by the serializer and its hold slot:
//   - ser_state_e   : serializer FSM states
//   - BIT_ORDER_*   : encoding of the MSB_FIRST parameter
//   - clog2_min1()  : counter width helper that never returns 0
package serializer_piso_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int BIT_ORDER_LSB = 0;
  localparam int BIT_ORDER_MSB = 1;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serializer_piso_stream_if.sv
// serializer_piso_stream_if
//   Parallel word handshake between the framing logic (master) and the
//   serializer (slave).
//   in_data  : parallel word, sampled only on in_valid & in_ready
//   in_valid : source has a word
//   in_ready : serializer holding slot is empty
interface serializer_piso_stream_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/serializer_hold_slot.sv
// serializer_hold_slot
//   One-entry valid/ready register in front of the shifter.
//   clk, rst    : clock, synchronous active-high reset
//   wr_data_i   : incoming word
//   wr_valid_i  : incoming word valid
//   wr_ready_o  : slot empty and not in reset (combinational)
//   pop_i       : shifter consumes the held word this edge
//   rd_data_o   : held word
//   full_o      : slot holds a word
module serializer_hold_slot
  import serializer_piso_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] data_q;
  logic                  full_q;
  logic                  push;

  // Ready depends only on the slot state, so a push and a pop can never
  // coincide: pop requires full, push requires empty.
  assign wr_ready_o = ~full_q & ~rst;
  assign push       = wr_valid_i & wr_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (push) begin
      data_q <= wr_data_i;
      full_q <= 1'b1;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign rd_data_o = data_q;
  assign full_o    = full_q;

endmodule

// File: rtl/serializer_piso_stream.sv
// serializer_piso_stream
//   Transmit-side parallel-in/serial-out serializer. Words enter through a
//   one-word hold slot and are shifted out one bit per bit_en strobe; a word
//   waiting in the slot is loaded on the edge that ends the previous word's
//   last bit, giving back-to-back transmission with no idle bit.
//   clk, rst  : clock, synchronous active-high reset
//   in_if     : slave side of the valid/ready word handshake
//   bit_en    : bit-period strobe
//   srl_out   : registered serial data (IDLE_LEVEL when no word in flight)
//   srl_frame : high during the first bit period of each word
//   tx_active : high while a word is being shifted
//   word_done : one-cycle pulse on the edge that ends a word's last bit
//
//   state | meaning
//   IDLE  | line at IDLE_LEVEL, waiting for a held word and a bit_en
//   SHIFT | word in flight, bit_cnt_q indexes the bit on srl_out
module serializer_piso_stream
  import serializer_piso_stream_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   MSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  serializer_piso_stream_if.slave  in_if,
  input  logic                     bit_en,
  output logic                     srl_out,
  output logic                     srl_frame,
  output logic                     tx_active,
  output logic                     word_done
);

  localparam int              CNT_W  = clog2_min1(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam bit              MSB_C  = (MSB_FIRST == BIT_ORDER_MSB);

  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  hold_ready;
  logic                  pop;
  logic                  last_bit;

  ser_state_e            state_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  srl_out_q;
  logic                  srl_frame_q;
  logic                  tx_active_q;
  logic                  word_done_q;

  serializer_hold_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (in_if.in_data),
    .wr_valid_i (in_if.in_valid),
    .wr_ready_o (hold_ready),
    .pop_i      (pop),
    .rd_data_o  (hold_data),
    .full_o     (hold_full)
  );

  assign in_if.in_ready = hold_ready;

  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST);
  // Load from the slot when idle, or seamlessly at the end of the last bit.
  assign pop      = bit_en & hold_full & ((state_q == IDLE) | last_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      srl_out_q   <= IDLE_LEVEL;
      srl_frame_q <= 1'b0;
      tx_active_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      if (bit_en) begin
        if (last_bit) begin
          word_done_q <= 1'b1;
        end
        if (pop) begin
          // shreg_q keeps the bits not yet on the line, pre-shifted so the
          // next bit always sits at the output end.
          state_q     <= SHIFT;
          bit_cnt_q   <= '0;
          srl_frame_q <= 1'b1;
          tx_active_q <= 1'b1;
          if (MSB_C) begin
            srl_out_q <= hold_data[DATA_WIDTH-1];
            shreg_q   <= hold_data << 1;
          end else begin
            srl_out_q <= hold_data[0];
            shreg_q   <= hold_data >> 1;
          end
        end else begin
          unique case (state_q)
            IDLE: begin
              srl_out_q <= IDLE_LEVEL;
            end
            SHIFT: begin
              if (last_bit) begin
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                srl_out_q   <= IDLE_LEVEL;
                srl_frame_q <= 1'b0;
                tx_active_q <= 1'b0;
              end else begin
                bit_cnt_q   <= bit_cnt_q + 1'b1;
                srl_frame_q <= 1'b0;
                if (MSB_C) begin
                  srl_out_q <= shreg_q[DATA_WIDTH-1];
                  shreg_q   <= shreg_q << 1;
                end else begin
                  srl_out_q <= shreg_q[0];
                  shreg_q   <= shreg_q >> 1;
                end
              end
            end
            default: begin
              state_q <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign srl_out   = srl_out_q;
  assign srl_frame = srl_frame_q;
  assign tx_active = tx_active_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_serializer_piso_stream.sv
module tb_serializer_piso_stream;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       vld;
  logic [7:0] dat;
  logic       use_msb;

  logic srl_l, frm_l, txa_l, wd_l;
  logic srl_m, frm_m, txa_m, wd_m;

  int checks;
  int errors;

  serializer_piso_stream_if #(.DATA_WIDTH(8)) if_l ();
  serializer_piso_stream_if #(.DATA_WIDTH(8)) if_m ();

  assign if_l.in_data  = dat;
  assign if_m.in_data  = dat;
  assign if_l.in_valid = vld & ~use_msb;
  assign if_m.in_valid = vld & use_msb;

  serializer_piso_stream #(
    .DATA_WIDTH (8),
    .MSB_FIRST  (0),
    .IDLE_LEVEL (1'b0)
  ) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in_if     (if_l.slave),
    .bit_en    (bit_en),
    .srl_out   (srl_l),
    .srl_frame (frm_l),
    .tx_active (txa_l),
    .word_done (wd_l)
  );

  serializer_piso_stream #(
    .DATA_WIDTH (8),
    .MSB_FIRST  (1),
    .IDLE_LEVEL (1'b0)
  ) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in_if     (if_m.slave),
    .bit_en    (bit_en),
    .srl_out   (srl_m),
    .srl_frame (frm_m),
    .tx_active (txa_m),
    .word_done (wd_m)
  );

  wire o_srl = use_msb ? srl_m : srl_l;
  wire o_frm = use_msb ? frm_m : frm_l;
  wire o_txa = use_msb ? txa_m : txa_l;
  wire o_wd  = use_msb ? wd_m  : wd_l;
  wire o_rdy = use_msb ? if_m.in_ready : if_l.in_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // seq[i] is the expected line value for the i-th bit period in time order.
  task automatic run_word(input string tag, input logic [7:0] w, input logic [7:0] seq);
    vld = 1'b1;
    dat = w;
    step();
    chk({tag, "_rdy_full"}, 32'(o_rdy), 32'd0);
    vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("%s_bit%0d", tag, i), 32'(o_srl), 32'(seq[i]));
      chk($sformatf("%s_frm%0d", tag, i), 32'(o_frm), 32'(i == 0));
      chk($sformatf("%s_txa%0d", tag, i), 32'(o_txa), 32'd1);
      chk($sformatf("%s_wd%0d", tag, i), 32'(o_wd), 32'd0);
      if (i == 0) chk({tag, "_rdy_after_load"}, 32'(o_rdy), 32'd1);
    end
    step();
    chk({tag, "_wd_pulse"}, 32'(o_wd), 32'd1);
    chk({tag, "_idle_line"}, 32'(o_srl), 32'd0);
    chk({tag, "_txa_fall"}, 32'(o_txa), 32'd0);
    step();
    chk({tag, "_wd_clear"}, 32'(o_wd), 32'd0);
    chk({tag, "_still_idle"}, 32'(o_srl), 32'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bit_en  = 1'b1;
    vld     = 1'b0;
    dat     = 8'h00;
    use_msb = 1'b0;

    // Reset and idle
    step();
    step();
    chk("rst_rdy_l", 32'(if_l.in_ready), 32'd0);
    chk("rst_rdy_m", 32'(if_m.in_ready), 32'd0);
    chk("rst_srl", 32'(srl_l), 32'd0);
    chk("rst_txa", 32'(txa_l), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_rdy_l", 32'(if_l.in_ready), 32'd1);
    chk("idle_rdy_m", 32'(if_m.in_ready), 32'd1);
    chk("idle_srl", 32'(srl_l), 32'd0);
    chk("idle_txa", 32'(txa_l), 32'd0);
    chk("idle_frm", 32'(frm_l), 32'd0);
    chk("idle_wd", 32'(wd_l), 32'd0);

    // A5 LSB first: 1,0,1,0,0,1,0,1
    run_word("lsb_a5", 8'hA5, 8'hA5);

    // MSB first: A5 -> 1,0,1,0,0,1,0,1 ; 01 -> 0,0,0,0,0,0,0,1
    use_msb = 1'b1;
    run_word("msb_a5", 8'hA5, 8'hA5);
    run_word("msb_01", 8'h01, 8'h80);
    use_msb = 1'b0;

    // Back-to-back FF then 00 with in_valid held
    vld = 1'b1;
    dat = 8'hFF;
    step();
    chk("b2b_rdy_before_load", 32'(o_rdy), 32'd0);
    dat = 8'h00;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) chk("b2b_rdy_after_load", 32'(o_rdy), 32'd1);
      if (i == 1) begin
        chk("b2b_rdy_second_held", 32'(o_rdy), 32'd0);
        vld = 1'b0;
      end
      chk($sformatf("b2b_bit%0d", i), 32'(o_srl), 32'(i < 8));
      chk($sformatf("b2b_frm%0d", i), 32'(o_frm), 32'((i == 0) || (i == 8)));
      chk($sformatf("b2b_txa%0d", i), 32'(o_txa), 32'd1);
      chk($sformatf("b2b_wd%0d", i), 32'(o_wd), 32'(i == 8));
    end
    step();
    chk("b2b_wd_end", 32'(o_wd), 32'd1);
    chk("b2b_idle", 32'(o_srl), 32'd0);
    chk("b2b_txa_end", 32'(o_txa), 32'd0);

    // Sparse bit_en every 4th cycle, word 3C: 0,0,1,1,1,1,0,0
    bit_en = 1'b0;
    vld    = 1'b1;
    dat    = 8'h3C;
    step();
    vld = 1'b0;
    for (int c = 0; c <= 33; c++) begin
      bit_en = ((c % 4) == 0) && (c <= 32);
      step();
      if (c < 32) begin
        chk($sformatf("sp_bit_c%0d", c), 32'(o_srl), 32'((c / 4 == 2) || (c / 4 == 3) || (c / 4 == 4) || (c / 4 == 5)));
        chk($sformatf("sp_frm_c%0d", c), 32'(o_frm), 32'(c < 4));
        chk($sformatf("sp_wd_c%0d", c), 32'(o_wd), 32'd0);
        chk($sformatf("sp_txa_c%0d", c), 32'(o_txa), 32'd1);
      end else if (c == 32) begin
        chk("sp_wd_at32", 32'(o_wd), 32'd1);
        chk("sp_idle_at32", 32'(o_srl), 32'd0);
        chk("sp_txa_at32", 32'(o_txa), 32'd0);
      end else begin
        chk("sp_wd_clear", 32'(o_wd), 32'd0);
      end
    end

    // Reset mid-word: F0 in flight, AA held
    bit_en = 1'b1;
    vld    = 1'b1;
    dat    = 8'hF0;
    step();
    dat = 8'hAA;
    step();
    chk("rm_bit0", 32'(o_srl), 32'd0);
    step();
    chk("rm_held_accept_rdy", 32'(o_rdy), 32'd0);
    vld = 1'b0;
    step();
    chk("rm_bit2", 32'(o_srl), 32'd0);
    chk("rm_txa_before", 32'(o_txa), 32'd1);
    rst = 1'b1;
    step();
    chk("rm_srl", 32'(o_srl), 32'd0);
    chk("rm_txa", 32'(o_txa), 32'd0);
    chk("rm_wd", 32'(o_wd), 32'd0);
    chk("rm_frm", 32'(o_frm), 32'd0);
    chk("rm_rdy_in_rst", 32'(o_rdy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rm_rdy_release", 32'(o_rdy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("rm_lost_srl%0d", i), 32'(o_srl), 32'd0);
      chk($sformatf("rm_lost_wd%0d", i), 32'(o_wd), 32'd0);
      chk($sformatf("rm_lost_txa%0d", i), 32'(o_txa), 32'd0);
    end
    chk("rm_rdy_end", 32'(o_rdy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
